// File: rtl/encoder_pkg.sv
// Shared constants for the 2^N-to-N arbitrating encoder: pick modes and FSM state encoding.
package encoder_pkg;
  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;
endpackage

// File: rtl/encoder_pick_2pNxN.sv
// Combinational pick: first set bit of vec at or after start (wrapping); start is
// ignored in fixed-priority mode so the search always begins at index 0.
module encoder_pick_2pNxN
  import encoder_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [2**N-1:0] vec,
  input  logic [N-1:0]    start,
  input  logic            mode,
  output logic [N-1:0]    idx,
  output logic            any
);
  localparam int W = 2**N;

  logic [N-1:0] base;
  logic [N-1:0] j;
  logic         found;

  assign base = mode ? start : '0;
  assign any  = |vec;

  // N-bit index arithmetic wraps modulo 2**N for free.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    j     = '0;
    for (int k = 0; k < W; k++) begin
      j = base + N'(k);
      if (!found && vec[j]) begin
        idx   = j;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/arb_encoder_2pnxn.sv
// Arbitrating 2^N-to-N encoder: serialises the set bits of a request vector as indices.
// Optional OUT_LAST output enabled by defining ARB_ENCODER_LAST_EN.
module arb_encoder_2pnxn
  import encoder_pkg::*;
#(
  parameter int N    = 2,
  parameter int MODE = 0
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [2**N-1:0] IN,
  input  logic            IN_VALID,
  output logic            IN_READY,
  output logic [N-1:0]    OUT,
  output logic            OUT_VALID,
  input  logic            OUT_READY
`ifdef ARB_ENCODER_LAST_EN
  ,
  output logic            OUT_LAST
`endif
);
  localparam int W = 2**N;

  state_t       state;
  logic [W-1:0] pend;
  logic [W-1:0] remain;
  logic [W-1:0] pvec;
  logic [N-1:0] ptr;
  logic [N-1:0] pstart;
  logic [N-1:0] pidx;
  logic         pany;

  assign remain = pend & ~(W'(1) << OUT);

  // One picker serves both the initial grant (from IN) and the follow-on grant
  // (from what survives the handshake, starting just past the granted index).
  assign pvec   = (state == ST_IDLE) ? IN  : remain;
  assign pstart = (state == ST_IDLE) ? ptr : OUT + N'(1);

  encoder_pick_2pNxN #(.N(N)) u_pick (
    .vec   (pvec),
    .start (pstart),
    .mode  (MODE == MODE_RR),
    .idx   (pidx),
    .any   (pany)
  );

  assign IN_READY  = (state == ST_IDLE);
  assign OUT_VALID = (state == ST_BUSY);

`ifdef ARB_ENCODER_LAST_EN
  assign OUT_LAST = (state == ST_BUSY) && (remain == '0);
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_IDLE;
      pend  <= '0;
      ptr   <= '0;
      OUT   <= '0;
    end else if (state == ST_IDLE) begin
      // An all-zero vector is consumed without producing a grant.
      if (IN_VALID && pany) begin
        pend  <= IN;
        OUT   <= pidx;
        state <= ST_BUSY;
      end
    end else if (OUT_READY) begin
      pend <= remain;
      ptr  <= OUT + N'(1);
      if (pany) OUT   <= pidx;
      else      state <= ST_IDLE;
    end
  end
endmodule

// File: tb/tb_arb_encoder_2pnxn.sv
// Bench for arb_encoder_2pnxn: fixed-priority and round-robin instances share stimulus,
// each checked every cycle against a set-of-indices model plus directed literal checks.
module tb_arb_encoder_2pnxn;
  localparam int N = 2;
  localparam int W = 4;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic [W-1:0] IN = '0;
  logic         IN_VALID = 1'b0;
  logic         OUT_READY = 1'b1;
  logic         ir [2];
  logic         ov [2];
  logic [N-1:0] out [2];
`ifdef ARB_ENCODER_LAST_EN
  logic         last [2];
`endif

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  arb_encoder_2pnxn #(.N(N), .MODE(0)) u0 (
    .CLK(CLK), .RST(RST), .IN(IN), .IN_VALID(IN_VALID), .IN_READY(ir[0]),
    .OUT(out[0]), .OUT_VALID(ov[0]), .OUT_READY(OUT_READY)
`ifdef ARB_ENCODER_LAST_EN
    , .OUT_LAST(last[0])
`endif
  );

  arb_encoder_2pnxn #(.N(N), .MODE(1)) u1 (
    .CLK(CLK), .RST(RST), .IN(IN), .IN_VALID(IN_VALID), .IN_READY(ir[1]),
    .OUT(out[1]), .OUT_VALID(ov[1]), .OUT_READY(OUT_READY)
`ifdef ARB_ENCODER_LAST_EN
    , .OUT_LAST(last[1])
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the pending set as an int bitmask, grants chosen by scanning from the pointer.
  bit m_busy [2];
  int m_pend [2];
  int m_ptr  [2];
  int m_out  [2];

  function automatic int pick(input int vec, input int start);
    for (int k = 0; k < W; k++)
      if (vec[(start + k) % W]) return (start + k) % W;
    return 0;
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int m = 0; m < 2; m++) begin
        m_busy[m] = 1'b0; m_pend[m] = 0; m_ptr[m] = 0; m_out[m] = 0;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        if (!m_busy[m]) begin
          if (IN_VALID && IN != 0) begin
            m_pend[m] = int'(IN);
            m_out[m]  = pick(m_pend[m], (m == 1) ? m_ptr[m] : 0);
            m_busy[m] = 1'b1;
          end
        end else if (OUT_READY) begin
          m_pend[m] = m_pend[m] & ~(1 << m_out[m]);
          m_ptr[m]  = (m_out[m] + 1) % W;
          if (m_pend[m] == 0) m_busy[m] = 1'b0;
          else m_out[m] = pick(m_pend[m], (m == 1) ? m_ptr[m] : 0);
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (!RST) begin
      for (int m = 0; m < 2; m++) begin
        chk("model in_ready", 32'(ir[m]), 32'(!m_busy[m]));
        chk("model out_valid", 32'(ov[m]), 32'(m_busy[m]));
        if (m_busy[m]) chk("model out", 32'(out[m]), 32'(m_out[m]));
`ifdef ARB_ENCODER_LAST_EN
        chk("model out_last", 32'(last[m]), 32'(m_busy[m] && $countones(m_pend[m]) == 1));
`endif
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [W-1:0] v);
    IN = v;
    IN_VALID = 1'b1;
    step();
    IN_VALID = 1'b0;
    IN = '0;
  endtask

  logic [W-1:0] vecs [5];
  int cyc;

  initial begin
    vecs[0] = 4'b1101; vecs[1] = 4'b0100; vecs[2] = 4'b1011;
    vecs[3] = 4'b1111; vecs[4] = 4'b0001;
    #1 RST = 1'b1;
    step(); step();
    for (int m = 0; m < 2; m++) begin
      chk("reset in_ready", 32'(ir[m]), 1);
      chk("reset out_valid", 32'(ov[m]), 0);
      chk("reset out", 32'(out[m]), 0);
    end
    RST = 1'b0;
    step();

    // fixed priority, back-to-back grants then bubble
    send(4'b1010);
    chk("A out first", 32'(out[0]), 1);
    chk("A valid first", 32'(ov[0]), 1);
    step();
    chk("A out second", 32'(out[0]), 3);
    step();
    chk("A valid after", 32'(ov[0]), 0);
    chk("A ready after", 32'(ir[0]), 1);

    // round robin pointer carried across vectors
    send(4'b0011);
    chk("B rr out0", 32'(out[1]), 0);
    step();
    chk("B rr out1", 32'(out[1]), 1);
    step();
    chk("B rr idle", 32'(ir[1]), 1);
    send(4'b1001);
    chk("B rr out3", 32'(out[1]), 3);
    step();
    chk("B rr wrap0", 32'(out[1]), 0);
    step();

    // stall holds the grant; IN ignored while busy
    OUT_READY = 1'b0;
    send(4'b0110);
    for (int i = 0; i < 3; i++) begin
      chk("C stall out", 32'(out[0]), 1);
      chk("C stall valid", 32'(ov[0]), 1);
      IN = 4'b1111;
      IN_VALID = 1'b1;
      step();
    end
    IN_VALID = 1'b0;
    IN = '0;
    OUT_READY = 1'b1;
    chk("C release out", 32'(out[0]), 1);
    step();
    chk("C next out", 32'(out[0]), 2);
    step();

    // all-zero vector consumed silently
    IN = '0;
    IN_VALID = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("D zero ready", 32'(ir[0]), 1);
      chk("D zero valid", 32'(ov[1]), 0);
    end
    IN_VALID = 1'b0;

    // reset mid-vector after advancing the rr pointer to 2
    send(4'b1111);
    chk("E rr first", 32'(out[1]), 3);
    step();
    chk("E rr second", 32'(out[1]), 0);
    step();
    step();
    chk("E rr fourth", 32'(out[1]), 2);
    #1 RST = 1'b1;
    #1;
    for (int m = 0; m < 2; m++) begin
      chk("E rst out", 32'(out[m]), 0);
      chk("E rst valid", 32'(ov[m]), 0);
      chk("E rst ready", 32'(ir[m]), 1);
    end
    step();
    RST = 1'b0;
    step();
    send(4'b0110);
    chk("E ptr restarted", 32'(out[1]), 1);
    step(); step();
    send(4'b1000);
    chk("E grant3", 32'(out[1]), 3);
    step();

    // directed table with intermittent OUT_READY
    for (int v = 0; v < 5; v++) begin
      send(vecs[v]);
      cyc = 0;
      while (!(ir[0] && ir[1]) && cyc < 20) begin
        OUT_READY = (cyc % 3) != 0;
        step();
        cyc++;
      end
      OUT_READY = 1'b1;
      if (cyc >= 20) chk("F timeout", 0, 1);
    end

`ifdef ARB_ENCODER_LAST_EN
    send(4'b0101);
    chk("G out first", 32'(out[0]), 0);
    chk("G last first", 32'(last[0]), 0);
    step();
    chk("G out final", 32'(out[0]), 2);
    chk("G last final", 32'(last[0]), 1);
    step();
`endif

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
